// File: rtl/sim_time_gate_mux_pkg.sv
// Shared definitions for the multi-channel sim-time hold/release gate.
// Holds the channel state encoding, config select codes and reset defaults.
package sim_time_gate_mux_pkg;

    typedef enum logic {
        CH_HOLD = 1'b0,
        CH_LIVE = 1'b1
    } ch_state_e;

    typedef enum logic {
        CFG_SEL_INIT = 1'b0,
        CFG_SEL_REL  = 1'b1
    } cfg_sel_e;

    localparam int unsigned NUM_CH_DEFAULT = 4;
    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned TIME_W_DEFAULT = 32;

    localparam logic [63:0] INIT_DEFAULT_C = 64'h3FE000346DC5D639;
    localparam logic [31:0] REL_DEFAULT_C  = 32'd10000;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_gate_channel.sv
// One gate channel: initial-value and release-time registers, HOLD/LIVE
// state and the registered output word.
module sim_gate_channel
    import sim_time_gate_mux_pkg::*;
#(
    parameter int unsigned       DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned       TIME_W       = TIME_W_DEFAULT,
    parameter logic [DATA_W-1:0] INIT_DEFAULT = DATA_W'(INIT_DEFAULT_C),
    parameter logic [TIME_W-1:0] REL_DEFAULT  = TIME_W'(REL_DEFAULT_C)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_i,
    input  logic              restart_i,
    input  logic              freeze_i,
    input  logic [TIME_W-1:0] sim_time_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              cfg_wr_i,
    input  logic              cfg_sel_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              live_o
);

    ch_state_e         state_q, state_d;
    logic [DATA_W-1:0] init_q,  init_d;
    logic [TIME_W-1:0] rel_q,   rel_d;
    logic [DATA_W-1:0] dout_q,  dout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_HOLD;
            init_q  <= INIT_DEFAULT;
            rel_q   <= REL_DEFAULT;
            dout_q  <= INIT_DEFAULT;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            rel_q   <= rel_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        rel_d   = rel_q;
        dout_d  = dout_q;

        if (sample_i) begin
            // A write or restart on a sample cycle still emits the old init word.
            if (cfg_wr_i || restart_i) begin
                state_d = CH_HOLD;
                dout_d  = init_q;
            end else if (state_q == CH_LIVE) begin
                if (!freeze_i) begin
                    dout_d = din_i;
                end
            end else if (!freeze_i && (sim_time_i > rel_q)) begin
                state_d = CH_LIVE;
                dout_d  = din_i;
            end else begin
                dout_d = init_q;
            end
        end else if (cfg_wr_i) begin
            state_d = CH_HOLD;
        end

        if (cfg_wr_i) begin
            if (cfg_sel_i == CFG_SEL_REL) begin
                rel_d = cfg_data_i[TIME_W-1:0];
            end else begin
                init_d = cfg_data_i;
            end
        end
    end

    assign dout_o = dout_q;
    assign live_o = (state_q == CH_LIVE);

endmodule

// File: rtl/sim_time_gate_mux.sv
// Multi-channel sim-time gate: restart detection, config decode, out_valid.
// Optional freeze input is enabled by defining SIM_GATE_FREEZE_EN.
module sim_time_gate_mux
    import sim_time_gate_mux_pkg::*;
#(
    parameter int unsigned       NUM_CH       = NUM_CH_DEFAULT,
    parameter int unsigned       DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned       TIME_W       = TIME_W_DEFAULT,
    parameter logic [DATA_W-1:0] INIT_DEFAULT = DATA_W'(INIT_DEFAULT_C),
    parameter logic [TIME_W-1:0] REL_DEFAULT  = TIME_W'(REL_DEFAULT_C)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [TIME_W-1:0]          sim_time,
    input  logic [NUM_CH*DATA_W-1:0]   din,
    input  logic                       cfg_we,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic                       cfg_sel,
    input  logic [DATA_W-1:0]          cfg_data,
`ifdef SIM_GATE_FREEZE_EN
    input  logic                       freeze,
`endif
    output logic                       out_valid,
    output logic [NUM_CH*DATA_W-1:0]   dout,
    output logic [NUM_CH-1:0]          live_mask,
    output logic                       restart
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [TIME_W-1:0] last_time_q;
    logic              first_seen_q;
    logic              out_valid_q;
    logic              restart_q;
    logic              restart_hit;
    logic              freeze_w;
    logic [NUM_CH-1:0] cfg_wr;

`ifdef SIM_GATE_FREEZE_EN
    assign freeze_w = freeze;
`else
    assign freeze_w = 1'b0;
`endif

    // Time running backwards (including wrap to 0) means the solver restarted.
    assign restart_hit = in_valid && first_seen_q && (sim_time < last_time_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_time_q  <= '0;
            first_seen_q <= 1'b0;
            out_valid_q  <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            restart_q   <= restart_hit;
            if (in_valid) begin
                last_time_q  <= sim_time;
                first_seen_q <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Select values with no matching channel simply decode to nothing.
            assign cfg_wr[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            sim_gate_channel #(
                .DATA_W       (DATA_W),
                .TIME_W       (TIME_W),
                .INIT_DEFAULT (INIT_DEFAULT),
                .REL_DEFAULT  (REL_DEFAULT)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .sample_i   (in_valid),
                .restart_i  (restart_hit),
                .freeze_i   (freeze_w),
                .sim_time_i (sim_time),
                .din_i      (din[gi*DATA_W +: DATA_W]),
                .cfg_wr_i   (cfg_wr[gi]),
                .cfg_sel_i  (cfg_sel),
                .cfg_data_i (cfg_data),
                .dout_o     (dout[gi*DATA_W +: DATA_W]),
                .live_o     (live_mask[gi])
            );
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign restart   = restart_q;

endmodule

// File: tb/tb_sim_time_gate_mux.sv
// Randomized self-checking bench for sim_time_gate_mux with a transaction-level
// model; three channels so an out-of-range channel select is reachable.
module tb_sim_time_gate_mux;

    localparam int NCH = 3;
    localparam int DW  = 64;
    localparam int TW  = 32;
    localparam logic [63:0] INIT0 = 64'h3FE000346DC5D639;
    localparam logic [63:0] D4    = 64'h4000000000000000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [TW-1:0]     sim_time = '0;
    logic [NCH*DW-1:0] din = '0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic              cfg_sel = 1'b0;
    logic [DW-1:0]     cfg_data = '0;
    logic              freeze = 1'b0;
    logic              out_valid;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    live_mask;
    logic              restart;

    sim_time_gate_mux #(.NUM_CH(NCH), .DATA_W(DW), .TIME_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sim_time  (sim_time),
        .din       (din),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
`ifdef SIM_GATE_FREEZE_EN
        .freeze    (freeze),
`endif
        .out_valid (out_valid),
        .dout      (dout),
        .live_mask (live_mask),
        .restart   (restart)
    );

    always #5 clk = ~clk;

    // Model state: what each channel holds after the next clock edge.
    logic [63:0] init_m [NCH];
    logic [31:0] rel_m  [NCH];
    bit          live_m [NCH];
    logic [63:0] dout_m [NCH];
    logic [31:0] last_m;
    bit          first_m;
    bit          exp_ov, exp_rs;
    int          vectors = 0;
    int          miscompares = 0;
    bit          check_en = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            init_m[k] = INIT0;
            rel_m[k]  = 32'd10000;
            live_m[k] = 1'b0;
            dout_m[k] = INIT0;
        end
        last_m = 0; first_m = 0; exp_ov = 0; exp_rs = 0;
    endtask

    function automatic logic [NCH-1:0] exp_live();
        logic [NCH-1:0] m;
        for (int k = 0; k < NCH; k++) m[k] = live_m[k];
        return m;
    endfunction

    // Apply the behavioural rules for one cycle of inputs.
    task automatic model_step();
        bit rs;
        rs = in_valid && first_m && (sim_time < last_m);
        for (int k = 0; k < NCH; k++) begin
            bit wr;
            wr = cfg_we && (int'(cfg_ch) == k);
            if (in_valid) begin
                if (wr || rs) begin
                    live_m[k] = 0; dout_m[k] = init_m[k];
                end else if (live_m[k]) begin
                    if (!freeze) dout_m[k] = din[k*DW +: DW];
                end else if (!freeze && sim_time > rel_m[k]) begin
                    live_m[k] = 1; dout_m[k] = din[k*DW +: DW];
                end else begin
                    dout_m[k] = init_m[k];
                end
            end else if (wr) begin
                live_m[k] = 0;
            end
            if (wr) begin
                if (cfg_sel) rel_m[k] = cfg_data[31:0];
                else init_m[k] = cfg_data;
            end
        end
        if (in_valid) begin
            last_m = sim_time; first_m = 1;
        end
        exp_ov = in_valid;
        exp_rs = rs;
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        miscompares++;
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) fail(name, act, exp);
    endtask

    // Single compare process: every cycle, shortly after the edge.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            vectors++;
            if (out_valid !== exp_ov) fail("out_valid", 64'(out_valid), 64'(exp_ov));
            if (restart !== exp_rs)   fail("restart", 64'(restart), 64'(exp_rs));
            if (live_mask !== exp_live()) fail("live_mask", 64'(live_mask), 64'(exp_live()));
            for (int k = 0; k < NCH; k++)
                if (dout[k*DW +: DW] !== dout_m[k])
                    fail($sformatf("dout[%0d]", k), dout[k*DW +: DW], dout_m[k]);
        end
    end

    task automatic cyc(input bit v, input logic [31:0] t, input logic [NCH*DW-1:0] d,
                       input bit we, input logic [1:0] ch, input bit sel,
                       input logic [63:0] data, input bit frz);
        @(negedge clk);
        in_valid = v; sim_time = t; din = d;
        cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_data = data; freeze = frz;
        model_step();
    endtask

    task automatic samp(input logic [31:0] t, input logic [NCH*DW-1:0] d);
        cyc(1, t, d, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, sim_time, din, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    logic [NCH*DW-1:0] d4, dr;
    logic [31:0]       tr;

    initial begin
        model_reset();
        check_en = 1'b1;
        d4 = {NCH{D4}};
        repeat (3) @(posedge clk);
        #2;
        lit("reset_out_valid", 64'(out_valid), 64'd0);
        lit("reset_live", 64'(live_mask), 64'd0);
        lit("reset_dout0", dout[0 +: DW], INIT0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t <= 10000; t++) samp(t, d4);
        settle();
        lit("hold_at_rel_live", 64'(live_mask), 64'd0);
        lit("hold_at_rel_dout2", dout[2*DW +: DW], INIT0);
        samp(10001, d4);
        settle();
        lit("release_live", 64'(live_mask), 64'h7);
        lit("release_dout1", dout[DW +: DW], D4);
        lit("release_ov", 64'(out_valid), 64'd1);
        idle();
        settle();
        lit("ov_drops", 64'(out_valid), 64'd0);

        cyc(0, sim_time, d4, 1, 2'd2, 1, 64'd50, 0);
        cyc(0, sim_time, d4, 1, 2'd0, 0, 64'd0, 0);
        for (int t = 0; t <= 100; t++) begin
            samp(t, d4);
            if (t == 0 || t == 50 || t == 51) begin
                settle();
                if (t == 0)  lit("sweep_restart", 64'(restart), 64'd1);
                if (t == 50) lit("ch2_hold_50", 64'(live_mask), 64'd0);
                if (t == 51) lit("ch2_live_51", 64'(live_mask), 64'h4);
            end
        end
        settle();
        lit("ch0_init_zero", dout[0 +: DW], 64'd0);
        lit("ch1_default", dout[DW +: DW], INIT0);

        samp(20000, d4);
        settle();
        lit("all_live_20000", 64'(live_mask), 64'h7);
        samp(5, d4);
        settle();
        lit("restart_pulse", 64'(restart), 64'd1);
        lit("restart_live", 64'(live_mask), 64'd0);
        lit("restart_dout0", dout[0 +: DW], 64'd0);
        samp(5, d4);
        settle();
        lit("no_second_pulse", 64'(restart), 64'd0);

        samp(30000, d4);
        cyc(1, 30000, d4, 1, 2'd1, 0, 64'h1111, 0);
        settle();
        lit("cfg_same_cycle_live", 64'(live_mask), 64'h5);
        lit("cfg_same_cycle_old_init", dout[DW +: DW], INIT0);
        samp(30001, d4);
        cyc(0, sim_time, d4, 1, 2'd3, 0, 64'hDEAD, 0);
        settle();
        lit("bad_ch_ignored", 64'(live_mask), 64'h7);
        samp(0, d4);
        settle();
        lit("wrap_restart", 64'(restart), 64'd1);
        lit("ch1_new_init", dout[DW +: DW], 64'h1111);
        lit("ch2_kept_init", dout[2*DW +: DW], INIT0);

`ifdef SIM_GATE_FREEZE_EN
        samp(40000, d4);
        dr = {NCH{64'h0123456789ABCDEF}};
        cyc(1, 40001, dr, 0, 0, 0, 0, 1);
        settle();
        lit("freeze_holds", dout[0 +: DW], D4);
        samp(40002, dr);
        settle();
        lit("unfreeze_follows", dout[0 +: DW], 64'h0123456789ABCDEF);
`endif

        tr = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v, we, sel, frz;
            logic [1:0]  ch;
            logic [63:0] data;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) tr = $urandom_range(0, 500);
            else tr = tr + $urandom_range(0, 40);
            for (int k = 0; k < NCH; k++) dr[k*DW +: DW] = {$urandom, $urandom};
            we = ($urandom_range(0, 19) == 0);
            ch = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            data = sel ? 64'($urandom_range(0, 2000)) : {$urandom, $urandom};
`ifdef SIM_GATE_FREEZE_EN
            frz = ($urandom_range(0, 7) == 0);
`else
            frz = 1'b0;
`endif
            cyc(v, tr, dr, we, ch, sel, data, frz);
        end
        idle();
        settle();
        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sim_time_gate_mux.md
Name: sim_time_gate_mux

Overview:
- Multi-channel successor to the single-channel hold-then-release stage.
- Each channel outputs a programmable initial value while simulation time is at or below its own release time. After that it forwards the live solver value.
- Detects a simulation restart (sim_time going backwards) and re-arms all channels.
- Sits between the solver datapath and downstream consumers, such as torque (Tm) and speed feeds, in the real-time turbine model.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- DATA_W, 64, data word width (extended single/double bit pattern, treated as opaque)
- TIME_W, 32, sim_time width
- INIT_DEFAULT, 64'h3FE000346DC5D639, reset value of every channel's initial-value register
- REL_DEFAULT, 10000, reset value of every channel's release-time register

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  qualifies sim_time/din for one cycle
- sim_time  in  TIME_W  current simulation step count
- din  in  NUM_CH*DATA_W  live values; channel k at [k*DATA_W +: DATA_W]
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel
- cfg_sel  in  1  0 = initial value, 1 = release time (low TIME_W bits of cfg_data)
- cfg_data  in  DATA_W  configuration word
- out_valid  out  1  dout valid, one cycle after in_valid
- dout  out  NUM_CH*DATA_W  gated outputs, same packing as din
- live_mask  out  NUM_CH  1 = channel in LIVE state
- restart  out  1  one-cycle pulse when a restart is detected

Behaviour:
- Reset (async, rst_n=0):
  - init_reg[k]=INIT_DEFAULT, rel_reg[k]=REL_DEFAULT, state[k]=HOLD
  - dout[k]=INIT_DEFAULT
  - out_valid=0, live_mask=0, restart=0
  - last_time=0, first_seen=0
- Per-channel FSM, evaluated only on in_valid cycles:
  - HOLD: output init_reg[k]. Go to LIVE when sim_time > rel_reg[k] (unsigned compare; equality stays in HOLD).
  - LIVE: output din[k]. Go to HOLD only on restart or on a cfg write to that channel.
- Output timing:
  - Transition and output take effect in the same registered update. The sample that first satisfies sim_time > rel already carries din.
  - Latency is 1 cycle: out_valid = in_valid delayed one cycle; dout/live_mask update on that edge.
  - When in_valid=0, dout holds its value and the FSM does not advance.
- Restart detection:
  - Condition: in_valid, first_seen=1, and sim_time < last_time.
  - Effect: all channels forced to HOLD and output init_reg; restart pulses with out_valid.
  - last_time updates on every in_valid. first_seen is set on the first in_valid.
  - Equal consecutive sim_time is not a restart.
- Configuration:
  - Writes take effect at the next clock edge.
  - A write forces the target channel to HOLD. It re-releases on a later valid sample per the new rel_reg.
  - cfg_ch >= NUM_CH: write ignored.
- Simultaneous events:
  - cfg write and in_valid on the same cycle: the write wins for its channel (channel goes HOLD, new value registered). Output on that edge uses the old init_reg.
  - Restart has priority over release for every channel.
- sim_time wrap to 0 counts as a restart (it is backwards).

Optional Feature:
- Macro: SIM_GATE_FREEZE_EN.
- When defined:
  - Adds input freeze (1 bit).
  - While freeze=1, LIVE channels hold their last dout instead of sampling din. HOLD channels are unaffected, and no HOLD->LIVE transitions occur.
  - out_valid still follows in_valid.
  - Restart still applies during freeze.
- When undefined: no freeze port; behaviour as above.

Decomposition:
- Shared include, alongside global parameters: FSM state encoding (HOLD=1'b0, LIVE=1'b1), cfg_sel codes, default INIT/REL constants.
- Sub-module sim_gate_channel: one channel's init/rel registers, FSM and output register, instantiated NUM_CH times via generate.
- Top level holds restart detection, last_time, config decode and out_valid.

Test Plan:
- Reset, then in_valid with sim_time=0..10000 and din=all 64'h4000000000000000 -> every dout=3FE000346DC5D639, live_mask=0.
- sim_time=10001 -> dout=din on that out_valid cycle, live_mask=all ones, out_valid exactly 1 cycle after in_valid.
- Config ch2 rel=50, ch0 init=64'h0; sweep sim_time 0..100 -> ch2 live from t=51; ch0 outputs 0 until t=10001; others unchanged.
- All live at t=20000, then t=5 -> restart pulse, all dout=init values, live_mask=0; repeat t=5 -> no second pulse.
- cfg write to ch1 on same cycle as valid t=30000 with ch1 LIVE -> ch1 HOLD from the next sample; others stay LIVE; cfg_ch=NUM_CH write ignored.
- With SIM_GATE_FREEZE_EN: freeze=1 while live, din changes -> dout unchanged. Release freeze -> dout follows din next sample.
